// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: N-stage load-use/mem/branch stall-flush controller with valid tracking and saturating counters
module pipe_hazard_ctrl #(
  parameter int NUM_STAGES = 5,
  parameter int REG_AW     = 5,
  parameter int LU_CYCLES  = 1,
  parameter int CNT_W      = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_if_valid,
  input  logic [REG_AW-1:0]     i_id_rs1,
  input  logic [REG_AW-1:0]     i_id_rs2,
  input  logic                  i_id_rs1_used,
  input  logic                  i_id_rs2_used,
  input  logic [REG_AW-1:0]     i_ex_rd,
  input  logic                  i_ex_mem_read,
  input  logic                  i_mem_busy,
  input  logic                  i_branch_taken,
  output logic [NUM_STAGES-1:0] o_stall,
  output logic [NUM_STAGES-1:0] o_flush,
  output logic [NUM_STAGES-1:0] o_stage_valid,
  output logic                  o_lu_active,
  output logic [CNT_W-1:0]      o_stall_cnt,
  output logic [CNT_W-1:0]      o_flush_cnt,
  output logic [CNT_W-1:0]      o_lu_cnt
);
  localparam int LW = $clog2(LU_CYCLES + 1);
  typedef enum logic {RUN, LU_STALL} state_t;
  state_t state, state_nxt;
  logic [LW-1:0] cnt, cnt_nxt;
  logic lu_hit, br, lu_entry;
  logic [NUM_STAGES-1:0] shift_in, valid_nxt;
  assign lu_hit = o_stage_valid[2] & o_stage_valid[1] & i_ex_mem_read & (i_ex_rd != '0) &
                  ((i_id_rs1_used & (i_id_rs1 == i_ex_rd)) | (i_id_rs2_used & (i_id_rs2 == i_ex_rd)));
  assign br = i_branch_taken & o_stage_valid[2];
  assign lu_entry = (state == RUN) & lu_hit & ~i_mem_busy & ~br;
  assign o_lu_active = (state == LU_STALL);
  assign shift_in = {o_stage_valid[NUM_STAGES-2:0], i_if_valid};
  assign valid_nxt = (o_stall & o_stage_valid) | (~o_stall & ~o_flush & shift_in);
  always_comb begin
    o_stall = '0;
    o_flush = '0;
    state_nxt = state;
    cnt_nxt = cnt;
    if (i_rst) o_flush = '1;
    else if (i_mem_busy) begin
      o_stall[NUM_STAGES-2:0] = '1;
      o_flush[NUM_STAGES-1] = 1'b1;
    end else if (br) begin
      o_flush[2:1] = 2'b11;
      state_nxt = RUN;
    end else if (o_lu_active | lu_hit) begin
      o_stall[1:0] = 2'b11;
      o_flush[2] = 1'b1;
      if (o_lu_active) begin
        cnt_nxt = cnt - LW'(1);
        state_nxt = (cnt == LW'(1)) ? RUN : LU_STALL;
      end else if (LU_CYCLES > 1) begin
        state_nxt = LU_STALL;
        cnt_nxt = LW'(LU_CYCLES - 1);
      end
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= RUN;
      cnt <= '0;
      o_stage_valid <= '0;
      o_stall_cnt <= '0;
      o_flush_cnt <= '0;
      o_lu_cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      o_stage_valid <= valid_nxt;
      o_stall_cnt <= o_stall_cnt + CNT_W'((|o_stall) & ~(&o_stall_cnt));
      o_flush_cnt <= o_flush_cnt + CNT_W'(br & ~i_mem_busy & ~(&o_flush_cnt));
      o_lu_cnt <= o_lu_cnt + CNT_W'(lu_entry & ~(&o_lu_cnt));
    end
  end
endmodule
